// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared defaults, FSM state and trace entry type for the change logger
package trace_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with a registered head entry and occupancy level
module trace_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = DEF_TS_W + DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [WIDTH-1:0] head;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == LVL_FULL);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = head;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
      // Head bypasses memory when the incoming entry becomes the new head.
      if (pop_ok) begin
        if (count > LVL_ONE) begin
          head <= mem[rd_ptr + PTR_ONE];
        end else if (push_ok) begin
          head <= wdata;
        end
      end else if (push_ok && empty) begin
        head <= wdata;
      end
    end
  end

endmodule

// File: rtl/change_logger.sv
// rtl/change_logger.sv - timestamps changes of a monitored value into a trace FIFO
module change_logger
  import trace_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      sample_in,
  input  logic                   clear_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_W-1:0]        out_ts,
  output logic [DATA_W-1:0]      out_data,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int ENT_W = TS_W + DATA_W;
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] last_sample;
  logic              push;
  logic              drop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ENT_W-1:0]  fifo_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ts          <= '0;
      last_sample <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + TS_ONE;
      if (state != IDLE) begin
        last_sample <= sample_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = PRIME;
      end
      PRIME: begin
        push      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        push = (sample_in != last_sample);
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Dropped entries count only when no pop makes room in the same cycle.
  assign drop = push && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_ovf) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({ts, sample_in}),
    .pop     (out_ready),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  assign out_valid         = !fifo_empty;
  assign {out_ts, out_data} = fifo_rdata;

endmodule

// File: tb/tb_change_logger.sv
// tb/tb_change_logger.sv - randomized and directed self-checking bench for change_logger
module tb_change_logger;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  sample_in;
  logic        clear_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ts;
  logic [7:0]  out_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [4:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  entry_t      mq[$];
  entry_t      seen[$];
  logic [15:0] m_ts;
  logic [7:0]  m_last;
  int          m_streak;
  logic        m_ovf;
  logic [7:0]  m_dc;

  change_logger #(.DATA_W(8), .TS_W(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sample_in  (sample_in),
    .clear_ovf  (clear_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ts     (out_ts),
    .out_data   (out_data),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    seen.delete();
    m_ts = '0;
    m_last = '0;
    m_streak = 0;
    m_ovf = 1'b0;
    m_dc = '0;
  endtask

  // Streak of enabled edges: 0 = idle, 1 = first logging cycle, 2+ = change detection.
  task automatic model_update();
    bit want, pop, drop;
    entry_t e;
    want = (m_streak == 1) || (m_streak >= 2 && sample_in != m_last);
    pop = out_ready && (mq.size() > 0);
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (want) begin
      if (mq.size() < DEPTH) begin
        e.ts = m_ts;
        e.data = sample_in;
        mq.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_dc = clear_ovf ? 8'd1 : (m_dc == 8'hFF ? 8'hFF : m_dc + 8'd1);
    end else if (clear_ovf) begin
      m_ovf = 1'b0;
      m_dc = '0;
    end
    if (m_streak >= 1) m_last = sample_in;
    m_streak = enable ? ((m_streak >= 2) ? 2 : m_streak + 1) : 0;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic tick();
    entry_t e;
    if (out_valid && out_ready) begin
      e.ts = out_ts;
      e.data = out_data;
      seen.push_back(e);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; sample_in = 8'h3C; clear_ovf = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d expected 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b expected 0", out_valid); end
    n_cmp++; if (out_ts !== 16'd0) begin n_err++; $display("FAIL reset_ts got %0h expected 0", out_ts); end
    n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL reset_data got %0h expected 0", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b expected 0", overflow); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_dc got %0d expected 0", drop_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_constant();
    enable = 1'b1; sample_in = 8'h00; out_ready = 1'b1; clear_ovf = 1'b0;
    do_reset();
    repeat (10) tick();
    n_cmp++; if (seen.size() != 1) begin n_err++; $display("FAIL const_count got %0d expected 1", seen.size()); end
    if (seen.size() >= 1) begin
      n_cmp++; if (seen[0].ts !== 16'd1) begin n_err++; $display("FAIL const_ts got %0d expected 1", seen[0].ts); end
      n_cmp++; if (seen[0].data !== 8'h00) begin n_err++; $display("FAIL const_data got %0h expected 0", seen[0].data); end
    end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL const_level got %0d expected 0", level); end
  endtask

  task automatic test_ramp();
    logic [15:0] ts0;
    seen.delete();
    out_ready = 1'b1;
    ts0 = m_ts;
    for (int i = 0; i < 8; i++) begin
      sample_in = 8'h05 + 8'(i);
      tick();
    end
    repeat (3) tick();
    n_cmp++; if (seen.size() != 8) begin n_err++; $display("FAIL ramp_count got %0d expected 8", seen.size()); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      n_cmp++;
      if (seen[i].data !== 8'h05 + 8'(i) || seen[i].ts !== ts0 + 16'(i)) begin
        n_err++;
        $display("FAIL ramp_entry%0d got ts=%0d data=%0h expected ts=%0d data=%0h",
                 i, seen[i].ts, seen[i].data, ts0 + 16'(i), 8'h05 + 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    seen.delete();
    out_ready = 1'b0;
    v = m_last;
    for (int i = 1; i <= 20; i++) begin
      sample_in = v + 8'(i);
      tick();
    end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d expected 16", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b expected 1", overflow); end
    n_cmp++; if (drop_count !== 8'd4) begin n_err++; $display("FAIL ovf_dc got %0d expected 4", drop_count); end
    out_ready = 1'b1;
    repeat (17) tick();
    n_cmp++; if (seen.size() != 16) begin n_err++; $display("FAIL ovf_drain_count got %0d expected 16", seen.size()); end
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      n_cmp++;
      if (seen[i].data !== v + 8'(i + 1)) begin
        n_err++; $display("FAIL ovf_drain%0d got %0h expected %0h", i, seen[i].data, v + 8'(i + 1));
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] v;
    seen.delete();
    out_ready = 1'b0;
    v = m_last;
    for (int i = 1; i <= 16; i++) begin
      sample_in = v + 8'(i);
      tick();
    end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL fpp_fill got %0d expected 16", level); end
    sample_in = v + 8'd17; out_ready = 1'b1;
    tick();
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL fpp_level got %0d expected 16", level); end
    n_cmp++; if (drop_count !== 8'd4) begin n_err++; $display("FAIL fpp_dc got %0d expected 4", drop_count); end
    sample_in = v + 8'd18; out_ready = 1'b0; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_drop_ovf got %0b expected 1", overflow); end
    n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL clr_drop_dc got %0d expected 1", drop_count); end
    out_ready = 1'b1;
    repeat (17) tick();
    n_cmp++; if (seen.size() != 17) begin n_err++; $display("FAIL fpp_count got %0d expected 17", seen.size()); end
    if (seen.size() == 17) begin
      n_cmp++; if (seen[16].data !== v + 8'd17) begin n_err++; $display("FAIL fpp_tail got %0h expected %0h", seen[16].data, v + 8'd17); end
      n_cmp++; if (seen[0].data !== v + 8'd1) begin n_err++; $display("FAIL fpp_head got %0h expected %0h", seen[0].data, v + 8'd1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    out_ready = 1'b0;
    v = m_last;
    for (int i = 1; i <= 7; i++) begin
      sample_in = v + 8'(i);
      tick();
    end
    n_cmp++; if (level !== 5'd7) begin n_err++; $display("FAIL mid_fill got %0d expected 7", level); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %0b expected 0", out_valid); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL mid_level got %0d expected 0", level); end
    @(negedge clk);
    @(negedge clk);
    sample_in = 8'hA5; out_ready = 1'b1; enable = 1'b1;
    reset_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (seen.size() != 1) begin n_err++; $display("FAIL mid_count got %0d expected 1", seen.size()); end
    if (seen.size() >= 1) begin
      n_cmp++; if (seen[0].ts !== 16'd1) begin n_err++; $display("FAIL mid_ts got %0d expected 1", seen[0].ts); end
      n_cmp++; if (seen[0].data !== 8'hA5) begin n_err++; $display("FAIL mid_data got %0h expected a5", seen[0].data); end
    end
  endtask

  task automatic test_random();
    int ready_pct;
    for (int blk = 0; blk < 6; blk++) begin
      ready_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int c = 0; c < 500; c++) begin
        enable    = ($urandom_range(0, 15) != 0);
        sample_in = 8'($urandom_range(0, 3));
        out_ready = ($urandom_range(0, 99) < ready_pct);
        clear_ovf = ($urandom_range(0, 63) == 0);
        tick();
        n_cmp++;
        if (level !== 5'(mq.size()) || out_valid !== (mq.size() > 0)) begin
          n_err++;
          $display("FAIL rnd_level c%0d got lvl=%0d vld=%0b expected lvl=%0d", c, level, out_valid, mq.size());
        end
        n_cmp++;
        if (overflow !== m_ovf || drop_count !== m_dc) begin
          n_err++;
          $display("FAIL rnd_ovf c%0d got ovf=%0b dc=%0d expected ovf=%0b dc=%0d", c, overflow, drop_count, m_ovf, m_dc);
        end
        if (mq.size() > 0) begin
          n_cmp++;
          if (out_ts !== mq[0].ts || out_data !== mq[0].data) begin
            n_err++;
            $display("FAIL rnd_head c%0d got ts=%0d data=%0h expected ts=%0d data=%0h",
                     c, out_ts, out_data, mq[0].ts, mq[0].data);
          end
        end
      end
    end
    clear_ovf = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; sample_in = '0; clear_ovf = 1'b0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_constant();
    test_ramp();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/change_logger.md
CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the monitored value.
REQ-002 SHALL have parameter TS_W, default 16, width of the cycle timestamp.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries, power of two >= 2.
REQ-004 SHALL have port clk  input  1  the single clock, with all state updated on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  logging enable, level-sensitive.
REQ-007 SHALL have port sample_in  input  DATA_W  monitored value, e.g. the counter output of the upstream counter stage.
REQ-008 SHALL have port clear_ovf  input  1  single-cycle pulse that clears overflow and drop_count.
REQ-009 SHALL have port out_valid  output  1  the head FIFO entry is available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_ts  output  TS_W  timestamp of the head entry.
REQ-012 SHALL have port out_data  output  DATA_W  value of the head entry.
REQ-013 SHALL have port overflow  output  1  sticky flag meaning at least one entry was dropped.
REQ-014 SHALL have port drop_count  output  8  dropped-entry count, saturating.
REQ-015 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL hold a TS_W timestamp counter that increments by 1 on every clk edge, regardless of enable, and wraps from all-ones to 0.
REQ-017 SHALL implement FSM states IDLE, PRIME and RUN.
  - IDLE->PRIME when enable=1.
  - PRIME->RUN unconditionally.
  - PRIME or RUN->IDLE when enable=0; this transition has priority.
REQ-018 In PRIME, SHALL push {timestamp, sample_in} unconditionally and load last_sample with sample_in.
REQ-019 In RUN, SHALL push {timestamp, sample_in} only when sample_in != last_sample, and SHALL update last_sample on every RUN cycle.
REQ-020 In IDLE, SHALL push nothing; last_sample holds its value.
REQ-021 Pushed timestamp SHALL equal the counter value in the detection cycle, before that edge's increment.
REQ-022 An entry pushed at edge N SHALL make out_valid=1 from edge N onward, giving zero extra cycles of latency when the FIFO was empty.
REQ-023 Handshake: an entry SHALL pop at a clk edge where out_valid=1 and out_ready=1.
  - out_ts and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Full with push and pop in the same cycle: the push SHALL be accepted and level SHALL be unchanged.
REQ-025 Full with push and no pop: the entry SHALL be dropped.
  - overflow SHALL be set.
  - drop_count SHALL increment, saturating at 255.
REQ-026 Empty with pop requested: no effect; out_valid=0 and out_ready is ignored.
REQ-027 clear_ovf SHALL zero overflow and drop_count at the next edge.
  - If a drop occurs in the same cycle, the drop SHALL win: overflow=1, drop_count=1.
REQ-028 level SHALL equal pushes minus pops since reset and SHALL never exceed DEPTH.
REQ-029 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 reset_n=0 SHALL asynchronously force the following, with no pending entries surviving:
  - state=IDLE;
  - timestamp=0, last_sample=0;
  - FIFO empty: level=0, out_valid=0;
  - overflow=0, drop_count=0;
  - out_ts=0, out_data=0.
REQ-031 Reset deassertion SHALL take effect at the first clk edge after release; reset mid-operation SHALL discard all FIFO contents.

Structure
REQ-032 Package trace_pkg SHALL hold:
  - default constants for DATA_W, TS_W and DEPTH;
  - the FSM state enum (IDLE, PRIME, RUN);
  - the entry struct {ts, data}.
REQ-033 The FIFO SHALL be a single sub-module trace_fifo (synchronous, registered head, full/empty/level outputs); FSM, timestamp and change detection SHALL live in change_logger.

Verification
REQ-034 Reset, then enable=1 with sample_in=0x00 constant for 10 cycles and out_ready=1 -> exactly one entry, {ts=1 (PRIME cycle), data=0x00}; no further entries.
REQ-035 Ramp sample_in +1 every cycle from 0x05 for 8 cycles in RUN, out_ready=1 -> 8 entries, data 0x05..0x0C, consecutive timestamps.
REQ-036 out_ready=0, 20 value changes with DEPTH=16 -> level=16, overflow=1, drop_count=4; first 16 values drained in order once out_ready=1.
REQ-037 Full FIFO with simultaneous change and out_ready=1 -> level remains 16, no drop, new entry at tail.
REQ-038 reset_n pulsed low mid-stream with level=7 -> out_valid=0 and level=0 immediately (asynchronous); first entry after re-enable has ts from the restarted counter.
REQ-039 clear_ovf pulse coincident with a drop -> overflow=1, drop_count=1 at next edge.
